// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART transmitter between NUM_REQ byte sources.
// One byte per grant: capture winner in IDLE, pulse trmt, wait for tx_done, pulse ack.
// Optional build macro UART_SRC_TAG_EN: each grant first sends the tag byte
// {TAG_BASE[7:3], grant_id}, then the data byte; a single ack follows the data byte.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req[NUM_REQ]       level request per source, held with stable data until ack
//   req_data[8*NUM_REQ] byte of source i on req_data[8*i+7:8*i]
//   ack[NUM_REQ]       one-cycle pulse when the byte of source i has been shifted out
//   grant_id[3]        source being served, valid while busy
//   busy               high from the launch cycle through the ack cycle
//   trmt               one-cycle start strobe to the transmitter
//   tx_data[8]         byte presented to the transmitter
//   tx_done            transmitter done flag (set at end of stop bit, cleared on trmt)
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter logic [7:0]  TAG_BASE = 8'hA0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 trmt,
  output logic [7:0]           tx_data,
  input  logic                 tx_done
);

  localparam int unsigned IDW = 3;
  localparam int unsigned BW  = 8;

  // Elaboration-time parameter sanity checks.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
  end
  if (TAG_BASE[2:0] != 3'b000) begin : g_tag_low_bits
    $warning("uart_tx_arbiter: TAG_BASE[2:0] is replaced by grant_id in the tag byte");
  end

`ifdef UART_SRC_TAG_EN
  typedef enum logic [2:0] {IDLE, TAG_LAUNCH, TAG_WAIT, LAUNCH, WAIT, DONE} state_t;
  logic [BW-1:0] data_q;
`else
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;
`endif

  state_t         state;
  logic [IDW-1:0] ptr;

  logic           win_vld_c;
  logic [IDW-1:0] win_id_c;
  logic [BW-1:0]  win_data_c;
  int unsigned    best_d_c;
  int unsigned    dist_c;

  // Round-robin pick: the requester closest to ptr (modulo NUM_REQ) wins.
  always_comb begin
    win_vld_c  = |req;
    win_id_c   = '0;
    win_data_c = '0;
    best_d_c   = NUM_REQ;
    dist_c     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      dist_c = (i >= 32'(ptr)) ? (i - 32'(ptr)) : (i + NUM_REQ - 32'(ptr));
      if (req[i] && (dist_c < best_d_c)) begin
        best_d_c   = dist_c;
        win_id_c   = IDW'(i);
        win_data_c = req_data[BW*i +: BW];
      end
    end
  end

  // Grant sequencer; every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      ack      <= '0;
      trmt     <= 1'b0;
      busy     <= 1'b0;
      grant_id <= '0;
      tx_data  <= '0;
`ifdef UART_SRC_TAG_EN
      data_q   <= '0;
`endif
    end else begin
      trmt <= 1'b0;
      ack  <= '0;
      case (state)
        IDLE: begin
          if (win_vld_c) begin
            grant_id <= win_id_c;
            busy     <= 1'b1;
            trmt     <= 1'b1;
`ifdef UART_SRC_TAG_EN
            data_q   <= win_data_c;
            tx_data  <= {TAG_BASE[7:3], win_id_c};
            state    <= TAG_LAUNCH;
`else
            tx_data  <= win_data_c;
            state    <= LAUNCH;
`endif
          end
        end
`ifdef UART_SRC_TAG_EN
        TAG_LAUNCH: state <= TAG_WAIT;
        // tx_done is stale-high only in the launch cycle, so it is fresh here.
        TAG_WAIT: begin
          if (tx_done) begin
            tx_data <= data_q;
            trmt    <= 1'b1;
            state   <= LAUNCH;
          end
        end
`endif
        LAUNCH: state <= WAIT;
        WAIT: begin
          if (tx_done) begin
            ack   <= NUM_REQ'(1) << grant_id;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          ptr   <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural 435 clk/bit transmitter plus a line decoder,
// directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned BAUD    = 435;
  localparam int unsigned FRAME   = 10 * BAUD;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic [2:0]           grant_id;
  logic                 busy;
  logic                 trmt;
  logic [7:0]           tx_data;
  logic                 tx_done;
  logic                 tx_line;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TAG_BASE(8'hA0)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
    .grant_id(grant_id), .busy(busy), .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done)
  );

  // Transmitter model: start, 8 data LSB first, stop; done at end of stop bit.
  logic        tx_active;
  logic [9:0]  tx_sh;
  int unsigned tx_cnt;
  int unsigned tx_bit;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_active <= 1'b0; tx_sh <= '1; tx_cnt <= 0; tx_bit <= 0; tx_done <= 1'b0;
    end else if (trmt) begin
      tx_sh <= {1'b1, tx_data, 1'b0}; tx_active <= 1'b1; tx_cnt <= 0; tx_bit <= 0;
      tx_done <= 1'b0;
    end else if (tx_active) begin
      if (tx_cnt == BAUD - 1) begin
        tx_cnt <= 0;
        tx_sh  <= {1'b1, tx_sh[9:1]};
        if (tx_bit == 9) begin
          tx_active <= 1'b0;
          tx_done   <= 1'b1;
        end else begin
          tx_bit <= tx_bit + 1;
        end
      end else begin
        tx_cnt <= tx_cnt + 1;
      end
    end
  end
  assign tx_line = tx_active ? tx_sh[0] : 1'b1;

  // Line decoder: mid-bit sampling, bytes pushed in arrival order.
  logic [7:0] rx_q[$];
  int         rx_ferr = 0;
  initial begin : rx_decoder
    logic [7:0] b;
    b = '0;
    forever begin
      @(posedge clk);
      if (rst_n === 1'b1 && tx_line === 1'b0) begin
        repeat (BAUD / 2) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(posedge clk);
          b[i] = tx_line;
        end
        repeat (BAUD) @(posedge clk);
        if (tx_line !== 1'b1) rx_ferr++;
        rx_q.push_back(b);
      end
    end
  end

  // Protocol monitor: counts strobes/acks, logs grant order, flags protocol breaks.
  int         trmt_cnt = 0;
  int         viol     = 0;
  int         ack_cnt[NUM_REQ];
  logic [2:0] order_q[$];
  logic       outstanding = 1'b0;
  logic [NUM_REQ-1:0] ack_prev = '0;
  always @(posedge clk) begin
    if (rst_n !== 1'b1) begin
      outstanding = 1'b0;
      ack_prev    = '0;
    end else begin
      if (trmt === 1'b1) begin
        if (outstanding) viol++;
        outstanding = 1'b1;
        trmt_cnt++;
        order_q.push_back(grant_id);
      end else if (tx_done === 1'b1) begin
        outstanding = 1'b0;
      end
      if ($countones(ack) > 1 || (ack & ack_prev) != '0) viol++;
      for (int i = 0; i < NUM_REQ; i++) if (ack[i] === 1'b1) ack_cnt[i]++;
      ack_prev = ack;
    end
  end

  task automatic apply_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Waits for n acks, dropping each requester's req on its ack.
  task automatic serve(input int n, output int got);
    int c;
    got = 0;
    c   = 0;
    while (got < n && c < n * int'(FRAME + 100)) begin
      @(negedge clk);
      c++;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ack[i] === 1'b1) begin
          req[i] = 1'b0;
          got++;
        end
      end
    end
  endtask

  task automatic test_reset;
    int lows;
    int acts;
    rst_n = 1'b0; req = '0; req_data = '0;
    repeat (3) @(negedge clk);
    total++; if (ack !== 4'b0000)   begin bad++; $display("FAIL rst_ack: got %b want 0000", ack); end
    total++; if (trmt !== 1'b0)     begin bad++; $display("FAIL rst_trmt: got %b want 0", trmt); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
    total++; if (grant_id !== 3'd0) begin bad++; $display("FAIL rst_grant_id: got %0d want 0", grant_id); end
    rst_n = 1'b1;
    lows = 0; acts = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_line !== 1'b1) lows++;
      if (busy !== 1'b0 || trmt !== 1'b0) acts++;
    end
    total++; if (lows != 0) begin bad++; $display("FAIL idle_line: got %0d low samples want 0", lows); end
    total++; if (acts != 0) begin bad++; $display("FAIL idle_quiet: got %0d active samples want 0", acts); end
  endtask

  task automatic test_single;
    int r0, a0, t0, n, wrong, acts;
    r0 = rx_q.size(); a0 = ack_cnt[2]; t0 = trmt_cnt;
    req_data[23:16] = 8'h5A;
    req[2] = 1'b1;
    @(negedge clk);
    total++; if (trmt !== 1'b1)     begin bad++; $display("FAIL single_trmt: got %b want 1", trmt); end
    total++; if (tx_data !== 8'h5A) begin bad++; $display("FAIL single_tx_data: got %h want 5a", tx_data); end
    total++; if (grant_id !== 3'd2) begin bad++; $display("FAIL single_grant: got %0d want 2", grant_id); end
    req_data[23:16] = 8'hFF;
    @(negedge clk);
    total++; if (trmt !== 1'b0) begin bad++; $display("FAIL single_trmt_width: got %b want 0", trmt); end
    n = 1; wrong = 0;
    while (ack[2] !== 1'b1 && n < int'(FRAME + 100)) begin
      if (busy !== 1'b1 || grant_id !== 3'd2 || tx_data !== 8'h5A) wrong++;
      @(negedge clk);
      n++;
    end
    total++; if (n != int'(FRAME + 2)) begin bad++; $display("FAIL single_ack_latency: got %0d want %0d", n, FRAME + 2); end
    total++; if (wrong != 0) begin bad++; $display("FAIL single_hold: got %0d bad cycles want 0", wrong); end
    total++; if (ack !== 4'b0100 || busy !== 1'b1) begin bad++; $display("FAIL single_ack_cycle: got ack=%b busy=%b want 0100/1", ack, busy); end
    req[2] = 1'b0;
    @(negedge clk);
    total++; if (ack !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL single_after: got ack=%b busy=%b want 0000/0", ack, busy); end
    acts = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || trmt !== 1'b0) acts++;
    end
    total++; if (acts != 0) begin bad++; $display("FAIL stale_done: got %0d active cycles want 0", acts); end
    total++; if (ack_cnt[2] != a0 + 1) begin bad++; $display("FAIL single_ack_count: got %0d want %0d", ack_cnt[2] - a0, 1); end
    total++; if (trmt_cnt != t0 + 1)   begin bad++; $display("FAIL single_trmt_count: got %0d want 1", trmt_cnt - t0); end
    total++;
    if (rx_q.size() != r0 + 1) begin bad++; $display("FAIL single_rx_len: got %0d want 1", rx_q.size() - r0); end
    else begin
      total++; if (rx_q[r0] !== 8'h5A) begin bad++; $display("FAIL single_rx: got %h want 5a", rx_q[r0]); end
    end
  endtask

  task automatic test_simultaneous;
    int a0[NUM_REQ];
    int r0, o0, t0, v0, got;
    logic [31:0] rx_seq;
    logic [11:0] ord_seq;
    apply_reset();
    a0 = ack_cnt; r0 = rx_q.size(); o0 = order_q.size(); t0 = trmt_cnt; v0 = viol;
    req_data = 32'h13121110;
    req = 4'b1111;
    serve(4, got);
    repeat (2) @(negedge clk);
    total++; if (got != 4) begin bad++; $display("FAIL all_acks: got %0d want 4", got); end
    total++; if (trmt_cnt != t0 + 4) begin bad++; $display("FAIL all_trmt_count: got %0d want 4", trmt_cnt - t0); end
    for (int i = 0; i < NUM_REQ; i++) begin
      total++;
      if (ack_cnt[i] != a0[i] + 1) begin bad++; $display("FAIL all_ack%0d_count: got %0d want 1", i, ack_cnt[i] - a0[i]); end
    end
    total++;
    if (order_q.size() != o0 + 4) begin bad++; $display("FAIL all_order_len: got %0d want 4", order_q.size() - o0); end
    else begin
      ord_seq = {order_q[o0], order_q[o0+1], order_q[o0+2], order_q[o0+3]};
      total++; if (ord_seq !== {3'd0, 3'd1, 3'd2, 3'd3}) begin bad++; $display("FAIL all_order: got %h want 053", ord_seq); end
    end
    total++;
    if (rx_q.size() != r0 + 4) begin bad++; $display("FAIL all_rx_len: got %0d want 4", rx_q.size() - r0); end
    else begin
      rx_seq = {rx_q[r0], rx_q[r0+1], rx_q[r0+2], rx_q[r0+3]};
      total++; if (rx_seq !== 32'h10111213) begin bad++; $display("FAIL all_rx: got %h want 10111213", rx_seq); end
    end
    total++; if (viol != v0)  begin bad++; $display("FAIL all_protocol: got %0d violations want 0", viol - v0); end
    total++; if (rx_ferr != 0) begin bad++; $display("FAIL all_framing: got %0d errors want 0", rx_ferr); end
  endtask

  task automatic test_fairness;
    int a0[NUM_REQ];
    int r0, o0, v0, got, c;
    logic [23:0] rx_seq;
    logic [8:0]  ord_seq;
    a0 = ack_cnt; r0 = rx_q.size(); o0 = order_q.size(); v0 = viol;
    req_data[15:8]  = 8'h31;
    req_data[31:24] = 8'h33;
    req[1] = 1'b1;
    req[3] = 1'b1;
    got = 0; c = 0;
    while (got < 3 && c < 3 * int'(FRAME + 100)) begin
      @(negedge clk);
      c++;
      if (ack[3] === 1'b1) begin req[3] = 1'b0; got++; end
      if (ack[1] === 1'b1) begin got++; if (got == 3) req[1] = 1'b0; end
    end
    repeat (2) @(negedge clk);
    total++; if (got != 3) begin bad++; $display("FAIL fair_acks: got %0d want 3", got); end
    total++;
    if (order_q.size() != o0 + 3) begin bad++; $display("FAIL fair_order_len: got %0d want 3", order_q.size() - o0); end
    else begin
      ord_seq = {order_q[o0], order_q[o0+1], order_q[o0+2]};
      total++; if (ord_seq !== {3'd1, 3'd3, 3'd1}) begin bad++; $display("FAIL fair_order: got %o want 131", ord_seq); end
    end
    total++;
    if (rx_q.size() != r0 + 3) begin bad++; $display("FAIL fair_rx_len: got %0d want 3", rx_q.size() - r0); end
    else begin
      rx_seq = {rx_q[r0], rx_q[r0+1], rx_q[r0+2]};
      total++; if (rx_seq !== 24'h313331) begin bad++; $display("FAIL fair_rx: got %h want 313331", rx_seq); end
    end
    total++; if (ack_cnt[1] != a0[1] + 2) begin bad++; $display("FAIL fair_ack1: got %0d want 2", ack_cnt[1] - a0[1]); end
    total++; if (ack_cnt[3] != a0[3] + 1) begin bad++; $display("FAIL fair_ack3: got %0d want 1", ack_cnt[3] - a0[3]); end
    total++; if (viol != v0) begin bad++; $display("FAIL fair_protocol: got %0d violations want 0", viol - v0); end
  endtask

  task automatic test_reset_mid_byte;
    int a0[NUM_REQ];
    int r0, got;
    a0 = ack_cnt;
    req_data[7:0] = 8'hC3;
    req[0] = 1'b1;
    @(negedge clk);
    total++; if (trmt !== 1'b1 || tx_data !== 8'hC3 || grant_id !== 3'd0) begin
      bad++; $display("FAIL mid_launch: got trmt=%b data=%h id=%0d want 1/c3/0", trmt, tx_data, grant_id); end
    req[0] = 1'b0;
    repeat (5 * BAUD) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || ack !== 4'b0000 || trmt !== 1'b0 || tx_data !== 8'h00 || grant_id !== 3'd0) begin
      bad++; $display("FAIL mid_reset_vals: got busy=%b ack=%b trmt=%b data=%h id=%0d want 0/0000/0/00/0",
                      busy, ack, trmt, tx_data, grant_id); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (11 * BAUD) @(negedge clk);
    total++; if (ack_cnt[0] != a0[0] || busy !== 1'b0) begin
      bad++; $display("FAIL mid_no_ack: got acks=%0d busy=%b want 0/0", ack_cnt[0] - a0[0], busy); end
    r0 = rx_q.size();
    req_data[7:0]   = 8'hA5;
    req_data[31:24] = 8'h3C;
    req = 4'b1001;
    @(negedge clk);
    total++; if (trmt !== 1'b1 || grant_id !== 3'd0 || tx_data !== 8'hA5) begin
      bad++; $display("FAIL mid_restart: got trmt=%b id=%0d data=%h want 1/0/a5", trmt, grant_id, tx_data); end
    req[3] = 1'b0;
    serve(1, got);
    repeat (20) @(negedge clk);
    total++; if (got != 1) begin bad++; $display("FAIL mid_restart_ack: got %0d want 1", got); end
    total++; if (ack_cnt[3] != a0[3] || busy !== 1'b0) begin
      bad++; $display("FAIL mid_dropped_req: got acks=%0d busy=%b want 0/0", ack_cnt[3] - a0[3], busy); end
    total++;
    if (rx_q.size() != r0 + 1) begin bad++; $display("FAIL mid_rx_len: got %0d want 1", rx_q.size() - r0); end
    else begin
      total++; if (rx_q[r0] !== 8'hA5) begin bad++; $display("FAIL mid_rx: got %h want a5", rx_q[r0]); end
    end
  endtask

`ifdef UART_SRC_TAG_EN
  task automatic test_tag;
    int a0, r0, t0, v0, got;
    logic [15:0] rx_seq;
    apply_reset();
    a0 = ack_cnt[1]; r0 = rx_q.size(); t0 = trmt_cnt; v0 = viol;
    req_data[15:8] = 8'h77;
    req[1] = 1'b1;
    @(negedge clk);
    total++; if (trmt !== 1'b1 || tx_data !== 8'hA1 || grant_id !== 3'd1) begin
      bad++; $display("FAIL tag_launch: got trmt=%b data=%h id=%0d want 1/a1/1", trmt, tx_data, grant_id); end
    serve(1, got);
    repeat (2) @(negedge clk);
    total++; if (got != 1) begin bad++; $display("FAIL tag_ack: got %0d want 1", got); end
    total++; if (ack_cnt[1] != a0 + 1) begin bad++; $display("FAIL tag_ack_count: got %0d want 1", ack_cnt[1] - a0); end
    total++; if (trmt_cnt != t0 + 2) begin bad++; $display("FAIL tag_trmt_count: got %0d want 2", trmt_cnt - t0); end
    total++; if (viol != v0) begin bad++; $display("FAIL tag_protocol: got %0d violations want 0", viol - v0); end
    total++;
    if (rx_q.size() != r0 + 2) begin bad++; $display("FAIL tag_rx_len: got %0d want 2", rx_q.size() - r0); end
    else begin
      rx_seq = {rx_q[r0], rx_q[r0+1]};
      total++; if (rx_seq !== 16'hA177) begin bad++; $display("FAIL tag_rx: got %h want a177", rx_seq); end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef UART_SRC_TAG_EN
    test_tag();
`else
    test_single();
    test_simultaneous();
    test_fairness();
    test_reset_mid_byte();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
